// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/execute request, grant, return and memory bus bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
);
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic                  ifu_gnt;
  logic                  ifu_rd_vld;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  exec_rd_req;
  logic                  exec_wr_req;
  logic [ADDR_WIDTH-1:0] exec_addr;
  logic [DATA_WIDTH-1:0] exec_wr_data;
  logic                  exec_gnt;
  logic                  exec_rd_vld;
  logic [DATA_WIDTH-1:0] exec_rd_data;
  logic                  mem_rd_req;
  logic                  mem_wr_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  arb_err;

  modport slave (
    input  ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_wr_req, exec_addr, exec_wr_data, mem_rd_data,
    output ifu_gnt, ifu_rd_vld, ifu_rd_data, exec_gnt, exec_rd_vld, exec_rd_data,
           mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, arb_err
  );

  modport master (
    output ifu_rd_req, ifu_rd_addr, exec_rd_req, exec_wr_req, exec_addr, exec_wr_data, mem_rd_data,
    input  ifu_gnt, ifu_rd_vld, ifu_rd_data, exec_gnt, exec_rd_vld, exec_rd_data,
           mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, arb_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/execute single-port memory arbiter; `MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t                state_q, state_d;
  logic                  win_exec_q, win_exec_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  ifu_pend, exec_pend, pick_exec, can_sel;

  // The requester granted in this ACCESS cycle is still holding its old request.
  assign ifu_pend  = bus.ifu_rd_req && !(state_q == ACCESS && !win_exec_q);
  assign exec_pend = (bus.exec_rd_req || bus.exec_wr_req) && !(state_q == ACCESS && win_exec_q);
  assign can_sel   = !(state_q == ACCESS && !wr_q);

`ifdef MEM_ARB_RR_EN
  logic last_exec_q;

  assign pick_exec = exec_pend && (!ifu_pend || !last_exec_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_exec_q <= 1'b0;
    end else if (can_sel && (ifu_pend || exec_pend)) begin
      last_exec_q <= pick_exec;
    end
  end
`else
  assign pick_exec = exec_pend;
`endif

  always_comb begin
    state_d    = state_q;
    win_exec_d = win_exec_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    if (!can_sel) begin
      state_d = RESP;
    end else if (ifu_pend || exec_pend) begin
      state_d    = ACCESS;
      win_exec_d = pick_exec;
      if (pick_exec) begin
        addr_d  = bus.exec_addr;
        wdata_d = bus.exec_wr_data;
        wr_d    = bus.exec_wr_req;
        if (bus.exec_rd_req && bus.exec_wr_req) begin
          err_d = 1'b1;
        end
      end else begin
        addr_d = bus.ifu_rd_addr;
        wr_d   = 1'b0;
      end
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      win_exec_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_exec_q <= win_exec_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  assign bus.mem_rd_req   = (state_q == ACCESS) && !wr_q;
  assign bus.mem_wr_req   = (state_q == ACCESS) && wr_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wr_data  = wdata_q;
  assign bus.ifu_gnt      = (state_q == ACCESS) && !win_exec_q;
  assign bus.exec_gnt     = (state_q == ACCESS) && win_exec_q;
  assign bus.ifu_rd_vld   = (state_q == RESP) && !win_exec_q;
  assign bus.exec_rd_vld  = (state_q == RESP) && win_exec_q;
  assign bus.ifu_rd_data  = bus.ifu_rd_vld ? bus.mem_rd_data : '0;
  assign bus.exec_rd_data = bus.exec_rd_vld ? bus.mem_rd_data : '0;
  assign bus.arb_err      = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard testbench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;

  // kind: 0 ifu gnt, 1 exec gnt, 2 ifu rd_vld, 3 exec rd_vld
  typedef struct {
    int kind;
    int cyc;
    int rd;
    int wr;
    int addr;
    int data;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  int            cyc = 0;
  int            n_pass = 0;
  int            n_total = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  exp_t          sb[$];

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (cyc == 0) begin
      mem[12'o200] <= 12'o7001;
      mem[12'o300] <= 12'o1111;
      mem[12'o301] <= 12'o2222;
      mem[12'o302] <= 12'o3333;
    end
    if (bus.mem_wr_req) mem[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.mem_rd_req) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  function automatic void chk(string name, longint act, longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'o%0o, expected 'o%0o (cycle %0d)", name, act, exp, cyc);
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic push(int kind, int c, int rd, int wr, int addr, int data);
    exp_t e;
    e.kind = kind; e.cyc = c; e.rd = rd; e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  task automatic wait_gnt(input bit is_exec);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (is_exec ? bus.exec_gnt : bus.ifu_gnt) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL gnt_timeout: %s gnt not seen within 20 cycles, required", is_exec ? "exec" : "ifu");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_read(input int a);
    bus.ifu_rd_req  = 1'b1;
    bus.ifu_rd_addr = a[AW-1:0];
    wait_gnt(1'b0);
    bus.ifu_rd_req  = 1'b0;
  endtask

  task automatic exec_op(input bit rd, input bit wr, input int a, input int d);
    bus.exec_rd_req  = rd;
    bus.exec_wr_req  = wr;
    bus.exec_addr    = a[AW-1:0];
    bus.exec_wr_data = d[DW-1:0];
    wait_gnt(1'b1);
    bus.exec_rd_req  = 1'b0;
    bus.exec_wr_req  = 1'b0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_ctl"}, {bus.ifu_gnt, bus.exec_gnt, bus.ifu_rd_vld, bus.exec_rd_vld,
                        bus.mem_rd_req, bus.mem_wr_req}, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wr_data"}, bus.mem_wr_data, 0);
    chk({tag, "_arb_err"}, bus.arb_err, 0);
    chk({tag, "_rd_data"}, {bus.ifu_rd_data, bus.exec_rd_data}, 0);
  endtask

  initial begin : monitor
    int   kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("ifu_rd_data_gated", bus.ifu_rd_vld ? 0 : bus.ifu_rd_data, 0);
        chk("exec_rd_data_gated", bus.exec_rd_vld ? 0 : bus.exec_rd_data, 0);
        chk("single_gnt_strobe", {bus.ifu_gnt & bus.exec_gnt, bus.mem_rd_req & bus.mem_wr_req}, 0);
        chk("strobe_with_gnt", bus.mem_rd_req | bus.mem_wr_req, bus.ifu_gnt | bus.exec_gnt);
        if (bus.ifu_gnt || bus.exec_gnt || bus.ifu_rd_vld || bus.exec_rd_vld) begin
          kind = bus.ifu_gnt ? 0 : bus.exec_gnt ? 1 : bus.ifu_rd_vld ? 2 : 3;
          if (sb.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: kind %0d at cycle %0d, required none", kind, cyc);
          end else begin
            e = sb.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (e.kind < 2) begin
              chk("mem_rd_req", bus.mem_rd_req, e.rd);
              chk("mem_wr_req", bus.mem_wr_req, e.wr);
              chk("mem_addr", bus.mem_addr, e.addr);
              if (e.wr != 0) chk("mem_wr_data", bus.mem_wr_data, e.data);
            end else begin
              chk("rd_data", kind == 2 ? bus.ifu_rd_data : bus.exec_rd_data, e.data);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: bench still running after 5000 cycles, required finish");
    $fatal(1);
  end

  initial begin : stimulus
    int c;
    bus.ifu_rd_req   = 1'b0;
    bus.ifu_rd_addr  = '0;
    bus.exec_rd_req  = 1'b0;
    bus.exec_wr_req  = 1'b0;
    bus.exec_addr    = '0;
    bus.exec_wr_data = '0;
    repeat (3) next();
    reset = 1'b0;
    @(negedge clk);
    check_zero("reset");
    mon_en = 1'b1;

    // fetch read: gnt at N+1, data at N+2
    next(); c = cyc;
    push(0, c + 1, 1, 0, 12'o200, 0);
    push(2, c + 2, 0, 0, 0, 12'o7001);
    ifu_read(12'o200);

    // execute write, then read back
    next(); c = cyc;
    push(1, c + 1, 0, 1, 12'o050, 12'o1234);
    exec_op(1'b0, 1'b1, 12'o050, 12'o1234);
    next(); c = cyc;
    push(1, c + 1, 1, 0, 12'o050, 0);
    push(3, c + 2, 0, 0, 0, 12'o1234);
    exec_op(1'b1, 1'b0, 12'o050, 0);

    // read and write together: write only, sticky error
    next(); c = cyc;
    push(1, c + 1, 0, 1, 12'o060, 12'o4321);
    exec_op(1'b1, 1'b1, 12'o060, 12'o4321);
    @(negedge clk);
    chk("arb_err_set", bus.arb_err, 1);
    next(); c = cyc;
    push(1, c + 1, 1, 0, 12'o060, 0);
    push(3, c + 2, 0, 0, 0, 12'o4321);
    exec_op(1'b1, 1'b0, 12'o060, 0);
    @(negedge clk);
    chk("arb_err_sticky", bus.arb_err, 1);

    // fetch request raised and dropped while exec read is in ACCESS: never served
    next(); c = cyc;
    push(1, c + 1, 1, 0, 12'o050, 0);
    push(3, c + 2, 0, 0, 0, 12'o1234);
    fork
      exec_op(1'b1, 1'b0, 12'o050, 0);
      begin
        next();
        bus.ifu_rd_req  = 1'b1;
        bus.ifu_rd_addr = 12'o200;
        next();
        bus.ifu_rd_req  = 1'b0;
      end
    join

    // reset during ACCESS of a read aborts it
    next(); c = cyc;
    push(0, c + 1, 1, 0, 12'o200, 0);
    bus.ifu_rd_req  = 1'b1;
    bus.ifu_rd_addr = 12'o200;
    next();
    reset = 1'b1;
    bus.ifu_rd_req = 1'b0;
    next();
    reset = 1'b0;
    @(negedge clk);
    check_zero("abort");
    repeat (3) next();

    // exec write then fetch read in back-to-back ACCESS cycles
    next(); c = cyc;
    push(1, c + 1, 0, 1, 12'o070, 12'o0707);
    push(0, c + 2, 1, 0, 12'o070, 0);
    push(2, c + 3, 0, 0, 0, 12'o0707);
    fork
      exec_op(1'b0, 1'b1, 12'o070, 12'o0707);
      ifu_read(12'o070);
    join

    // simultaneous reads: exec first, fetch gnt at N+3
    next(); c = cyc;
    push(1, c + 1, 1, 0, 12'o301, 0);
    push(3, c + 2, 0, 0, 0, 12'o2222);
    push(0, c + 3, 1, 0, 12'o300, 0);
    push(2, c + 4, 0, 0, 0, 12'o1111);
    fork
      ifu_read(12'o300);
      exec_op(1'b1, 1'b0, 12'o301, 0);
    join

    // exec keeps requesting while fetch waits
    next(); c = cyc;
    push(1, c + 1, 1, 0, 12'o301, 0);
    push(3, c + 2, 0, 0, 0, 12'o2222);
`ifdef MEM_ARB_RR_EN
    push(0, c + 3, 1, 0, 12'o300, 0);
    push(2, c + 4, 0, 0, 0, 12'o1111);
    push(1, c + 5, 1, 0, 12'o302, 0);
    push(3, c + 6, 0, 0, 0, 12'o3333);
`else
    push(1, c + 3, 1, 0, 12'o302, 0);
    push(3, c + 4, 0, 0, 0, 12'o3333);
    push(0, c + 5, 1, 0, 12'o300, 0);
    push(2, c + 6, 0, 0, 0, 12'o1111);
`endif
    fork
      ifu_read(12'o300);
      begin
        exec_op(1'b1, 1'b0, 12'o301, 0);
        exec_op(1'b1, 1'b0, 12'o302, 0);
      end
    join

    repeat (4) next();
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: ADDR_WIDTH, default 12, address width.
REQ-002 Parameter: DATA_WIDTH, default 12, data width.
REQ-003 Port: clk  input  1  single free-running clock.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: ifu_rd_req  input  1  fetch read request; held until ifu_gnt.
REQ-006 Port: ifu_rd_addr  input  ADDR_WIDTH  fetch address.
REQ-007 Port: ifu_gnt  output  1  one-cycle pulse; fetch access issued.
REQ-008 Port: ifu_rd_vld / ifu_rd_data  output  1 / DATA_WIDTH  fetch read return.
REQ-009 Port: exec_rd_req / exec_wr_req  input  1 / 1  execute-unit read or write request; held until exec_gnt.
REQ-010 Port: exec_addr / exec_wr_data  input  ADDR_WIDTH / DATA_WIDTH  execute-unit address and write data.
REQ-011 Port: exec_gnt  output  1  one-cycle pulse; execute access issued.
REQ-012 Port: exec_rd_vld / exec_rd_data  output  1 / DATA_WIDTH  execute-unit read return.
REQ-013 Port: mem_rd_req / mem_wr_req  output  1 / 1  memory strobes.
REQ-014 Port: mem_addr / mem_wr_data  output  ADDR_WIDTH / DATA_WIDTH  memory address and write data.
REQ-015 Port: mem_rd_data  input  DATA_WIDTH  memory read data, valid the cycle after mem_rd_req.
REQ-016 Port: arb_err  output  1  sticky protocol-error flag.

Function
REQ-017 The block SHALL implement a three-state FSM: IDLE, ACCESS, RESP.
REQ-018 In IDLE or RESP, with any request pending, the FSM SHALL select a winner and enter ACCESS next cycle; with no request pending it SHALL go to (or stay in) IDLE.
REQ-019 In ACCESS the block SHALL register and drive mem_addr, mem_wr_data and exactly one of mem_rd_req or mem_wr_req for exactly one cycle, and pulse the winner's gnt in that same cycle.
REQ-020 A read in ACCESS SHALL be followed by RESP; a write SHALL go directly back to IDLE, or to ACCESS if a request is pending.
REQ-021 In RESP the block SHALL assert the winner's rd_vld for one cycle, with rd_data = mem_rd_data passed through combinationally.
REQ-022 Latency: request first seen at cycle N (FSM in IDLE) -> gnt and mem strobe at N+1 -> rd_vld at N+2.
REQ-023 Maximum throughput SHALL be one read per 2 cycles or one write per cycle.
REQ-024 Default arbitration SHALL be fixed priority: execute unit over fetch.
REQ-025 When exec_rd_req and exec_wr_req are both high, the block SHALL perform the write only and set arb_err.
REQ-026 A requester deasserting its request before gnt SHALL be treated as withdrawn, with no memory access issued for it.
REQ-027 rd_data outputs SHALL be 0 whenever the corresponding rd_vld is low.
REQ-028 No mem strobe SHALL be asserted outside ACCESS.
REQ-029 At most one gnt SHALL be asserted per cycle.

Reset
REQ-030 While reset is high at a clk edge, the FSM SHALL go to IDLE and all outputs (gnt, vld, strobes, addr, wr_data, arb_err, round-robin pointer) SHALL be 0 next cycle.
REQ-031 A reset in ACCESS or RESP SHALL abort the transaction, and no rd_vld SHALL be issued for it.

Configuration
REQ-032 With MEM_ARB_RR_EN defined, arbitration SHALL be round-robin via a 1-bit last-winner register; when both request, the requester that did not win last SHALL win; the pointer resets to "fetch won last".
REQ-033 Without MEM_ARB_RR_EN, REQ-024 fixed priority SHALL apply and no pointer register SHALL exist.

Verification
REQ-034 After reset, ifu_rd_req=1, addr=0o200, memory[0o200]=0o7001 -> ifu_gnt and mem_rd_req at N+1, ifu_rd_vld with data 0o7001 at N+2.
REQ-035 exec_wr_req=1, addr=0o050, data=0o1234 -> mem_wr_req at N+1, exec_gnt at N+1, no exec_rd_vld; a following read of 0o050 returns 0o1234.
REQ-036 ifu and exec read simultaneously, held -> fixed: exec served first, ifu gnt at N+3; with MEM_ARB_RR_EN, repeated contention alternates grants exec/ifu/exec.
REQ-037 exec_rd_req and exec_wr_req both high -> write only, arb_err=1 and stays 1 until reset.
REQ-038 Reset asserted in the ACCESS cycle of a read -> no rd_vld afterward, all outputs 0, FSM in IDLE.
